seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider. It performs one shift-and-trial-subtract step per clock on the team's n-bit add/subtract datapath, using A−B with carry-in 1, where carry-out 1 means no borrow. It is the inverse companion of the combinational adder/subtractor, recovering quotient and remainder from repeated subtraction. It sits beside the arithmetic unit as a start/done-handshaked coprocessor.

---
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One shift-and-trial-subtract step per clock, start/done handshake.
module seq_divider #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [n-1:0]  q_r;
  logic [n-1:0]  d_r;
  logic [n-1:0]  r_r;
  logic [CW-1:0] cnt;

  logic [n:0]    r_sh;
  logic [n:0]    t;
  logic          borrow;
  logic [n-1:0]  q_nx;
  logic [n-1:0]  r_nx;
  logic          last;

  // r_r only ever holds values below the divisor, so its shifted
  // copy fits in n+1 bits and the trial difference's MSB is the borrow
  always_comb begin
    r_sh   = {r_r, q_r[n-1]};
    t      = r_sh + ~{1'b0, d_r} + {{n{1'b0}}, 1'b1};
    borrow = t[n];
    q_nx   = {q_r[n-2:0], ~borrow};
    r_nx   = borrow ? r_sh[n-1:0] : t[n-1:0];
    last   = (cnt == CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          nxt = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (last) nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r         <= '0;
      d_r         <= '0;
      r_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              q_r <= dividend;
              r_r <= '0;
              d_r <= divisor;
              cnt <= CW'(n);
            end
          end
        end
        S_RUN: begin
          q_r <= q_nx;
          r_r <= r_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            quotient    <= q_nx;
            remainder   <= r_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider
// against a plain-arithmetic quotient/remainder model.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int passes = 0;

  seq_divider #(.n(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input int a, input int b,
    output int q, output int r, output bit z
  );
    if (b == 0) begin
      q = (1 << N) - 1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Runs one operation from IDLE; returns what was observed.
  task automatic run_op(
    input int a, input int b,
    output int lat, output int q, output int r,
    output bit z, output int bcyc, output bit pulse1
  );
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    lat  = 1;
    bcyc = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy === 1'b1) bcyc++;
    q = int'(quotient);
    r = int'(remainder);
    z = div_by_zero;
    @(posedge clk); #1;
    pulse1 = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0)
      $display("FAIL reset: got b%0b d%0b q%0d r%0d z%0b want 0",
               busy, done, quotient, remainder, div_by_zero);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: busy %0b done %0b want 0 0",
               busy, done);
    else passes++;
  endtask

  task automatic test_basic();
    int lat, q, r, bc;
    bit z, p;
    run_op(13, 3, lat, q, r, z, bc, p);
    checks++;
    if (lat != N + 1) $display("FAIL basic_lat: got %0d want %0d", lat, N + 1);
    else passes++;
    checks++;
    if (q != 4 || r != 1 || z != 1'b0)
      $display("FAIL basic_res: got q%0d r%0d z%0b want q4 r1 z0", q, r, z);
    else passes++;
    checks++;
    if (bc != N + 1) $display("FAIL basic_busy: got %0d want %0d", bc, N + 1);
    else passes++;
    checks++;
    if (!p) $display("FAIL basic_pulse: got multi-cycle want single");
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1)
      $display("FAIL basic_hold: got q%0d r%0d want q4 r1", quotient, remainder);
    else passes++;
  endtask

  task automatic test_sweep();
    int lat, q, r, bc, eq, er;
    bit z, ez, p;
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 1; b < (1 << N); b++) begin
        model(a, b, eq, er, ez);
        run_op(a, b, lat, q, r, z, bc, p);
        checks++;
        if (q != eq || r != er || z != ez)
          $display("FAIL sweep %0d/%0d: got q%0d r%0d z%0b want q%0d r%0d z%0b",
                   a, b, q, r, z, eq, er, ez);
        else passes++;
        checks++;
        if (lat != N + 1 || !p)
          $display("FAIL sweep_timing %0d/%0d: got lat %0d pulse %0b want %0d 1",
                   a, b, lat, p, N + 1);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    int a, b, lat, q, r, bc, eq, er, el;
    bit z, ez, p;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      if (i % 5 == 0) b = 0;
      model(a, b, eq, er, ez);
      el = ez ? 1 : N + 1;
      run_op(a, b, lat, q, r, z, bc, p);
      checks++;
      if (q != eq || r != er || z != ez || lat != el || bc != el || !p)
        $display("FAIL random %0d/%0d: got q%0d r%0d z%0b lat%0d busy%0d want q%0d r%0d z%0b lat%0d",
                 a, b, q, r, z, lat, bc, eq, er, ez, el);
      else passes++;
    end
  endtask

  task automatic test_div_by_zero();
    int lat, q, r, bc;
    bit z, p;
    run_op(7, 0, lat, q, r, z, bc, p);
    checks++;
    if (lat != 1 || bc != 1 || !p)
      $display("FAIL dbz_timing: got lat %0d busy %0d pulse %0b want 1 1 1",
               lat, bc, p);
    else passes++;
    checks++;
    if (q != 15 || r != 7 || z != 1'b1)
      $display("FAIL dbz_res: got q%0d r%0d z%0b want q15 r7 z1", q, r, z);
    else passes++;
    run_op(15, 1, lat, q, r, z, bc, p);
    checks++;
    if (q != 15 || r != 0 || z != 1'b0)
      $display("FAIL dbz_next: got q%0d r%0d z%0b want q15 r0 z0", q, r, z);
    else passes++;
  endtask

  task automatic test_edges();
    int lat, q, r, bc;
    bit z, p;
    run_op(2, 6, lat, q, r, z, bc, p);
    checks++;
    if (q != 0 || r != 2 || z != 1'b0)
      $display("FAIL small_dividend: got q%0d r%0d want q0 r2", q, r);
    else passes++;
    run_op(15, 15, lat, q, r, z, bc, p);
    checks++;
    if (q != 1 || r != 0 || z != 1'b0)
      $display("FAIL equal_ops: got q%0d r%0d want q1 r0", q, r);
    else passes++;
  endtask

  task automatic test_ignore_start();
    int lat;
    bit extra;
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; dividend = 4'd3; divisor = 4'd0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != N + 1 || quotient !== 4'd2 || remainder !== 4'd2)
      $display("FAIL ignore_start: got lat %0d q%0d r%0d want lat %0d q2 r2",
               lat, quotient, remainder, N + 1);
    else passes++;
    extra = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) $display("FAIL ignore_queued: got busy after done want idle");
    else passes++;
  endtask

  task automatic test_async_reset();
    int lat, q, r, bc;
    bit z, p, seen;
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0)
      $display("FAIL async_reset: got b%0b d%0b q%0d r%0d z%0b want 0",
               busy, done, quotient, remainder, div_by_zero);
    else passes++;
    @(posedge clk); #2;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL abandoned_op: got done/busy after reset want idle");
    else passes++;
    run_op(14, 3, lat, q, r, z, bc, p);
    checks++;
    if (q != 4 || r != 2 || z != 1'b0 || lat != N + 1)
      $display("FAIL post_reset_op: got q%0d r%0d lat %0d want q4 r2 lat %0d",
               q, r, lat, N + 1);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int first, second, n_ok;
    bit prev, dbl;
    logic [N-1:0] q2, r2;
    first = 0; second = 0; prev = 1'b0; dbl = 1'b0;
    q2 = '0; r2 = '0;
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (prev) dbl = 1'b1;
        if (first == 0) first = c;
        else if (second == 0) begin
          second = c;
          q2 = quotient;
          r2 = remainder;
        end
      end
      prev = (done === 1'b1);
    end
    start = 1'b0;
    checks++;
    if (first != N + 1 || second - first != N + 2)
      $display("FAIL b2b_timing: got first %0d interval %0d want %0d %0d",
               first, second - first, N + 1, N + 2);
    else passes++;
    checks++;
    if (dbl) $display("FAIL b2b_pulse: got consecutive done want single");
    else passes++;
    checks++;
    if (q2 !== 4'd5 || r2 !== 4'd1)
      $display("FAIL b2b_res: got q%0d r%0d want q5 r1", q2, r2);
    else passes++;
    n_ok = 0;
    while (busy !== 1'b0 && n_ok < 20) begin
      @(posedge clk); #1;
      n_ok++;
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_drain: got busy %0b want 0", busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_div_by_zero();
    test_edges();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
